// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 frame sequencer: FSM state encoding,
// ILI9341 command codes and pixel/range-word helpers.
package lt24_pkg;

  typedef enum logic [3:0] {
    ST_INIT_SLPOUT,
    ST_INIT_WAIT,
    ST_INIT_DISPON,
    ST_IDLE,
    ST_COL_CMD,
    ST_COL_DATA,
    ST_PAGE_CMD,
    ST_PAGE_DATA,
    ST_MEMWR_CMD,
    ST_PIXELS,
    ST_DONE
  } state_t;

  localparam logic [15:0] CMD_SLPOUT  = 16'h0011;
  localparam logic [15:0] CMD_DISPON  = 16'h0029;
  localparam logic [15:0] CMD_CASET   = 16'h002A;
  localparam logic [15:0] CMD_PASET   = 16'h002B;
  localparam logic [15:0] CMD_RAMWR   = 16'h002C;
  localparam logic [15:0] PIXEL_WHITE = 16'hFFFF;

  // Widen each channel by replicating its top bit(s) so 0xF maps to full scale.
  function automatic logic [15:0] rgb444_to_565(input logic [11:0] rgb);
    return {rgb[11:8], rgb[11], rgb[7:4], rgb[7:6], rgb[3:0], rgb[3]};
  endfunction

  // Data word idx (0..3) of a CASET/PASET range 0..last: start hi/lo, end hi/lo.
  function automatic logic [15:0] range_word(input logic [15:0] last,
                                             input logic [1:0]  idx);
    case (idx)
      2'd2:    return {8'h00, last[15:8]};
      2'd3:    return {8'h00, last[7:0]};
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/lt24_bus_writer.sv
// Two-cycle 8080-style write engine: phase 0 strobes wr_n low, phase 1 releases it.
// A new word offered during phase 1 (the word-done cycle) follows back-to-back.
module lt24_bus_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_word_valid,
  input  logic        i_word_rs,
  input  logic [15:0] i_word_data,
  output logic        o_word_done,
  output logic        o_cs_n,
  output logic        o_rs,
  output logic        o_wr_n,
  output logic [15:0] o_data
);

  logic        r_cs_n;
  logic        r_wr_n;
  logic        r_rs;
  logic [15:0] r_data;
  logic        r_phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_rs    <= 1'b0;
      r_data  <= 16'h0000;
      r_phase <= 1'b0;
    end else if (i_word_valid && (r_cs_n || r_phase)) begin
      r_cs_n  <= 1'b0;
      r_wr_n  <= 1'b0;
      r_phase <= 1'b0;
      r_rs    <= i_word_rs;
      r_data  <= i_word_data;
    end else if (!r_cs_n && !r_phase) begin
      r_wr_n  <= 1'b1;
      r_phase <= 1'b1;
    end else begin
      r_cs_n  <= 1'b1;
      r_phase <= 1'b0;
    end
  end

  assign o_word_done = !r_cs_n && r_phase;
  assign o_cs_n      = r_cs_n;
  assign o_rs        = r_rs;
  assign o_wr_n      = r_wr_n;
  assign o_data      = r_data;

endmodule

// File: rtl/lt24_frame_sequencer.sv
// LT24 frame sequencer: optional panel init, then per-start full-screen redraw
// of a solid background with a white square sprite. Init enabled by LT24_SEQ_INIT_EN.
module lt24_frame_sequencer
  import lt24_pkg::*;
#(
  parameter int H_RES     = 240,
  parameter int V_RES     = 320,
  parameter int SQ_SIZE   = 16,
  parameter int INIT_WAIT = 6000000
) (
  input  logic        clock_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic [11:0] pattern,
  input  logic [31:0] vx,
  input  logic [31:0] vy,
  output logic        busy,
  output logic        finish_flag,
  output logic [31:0] counter,
  output logic        lt24_cs_n,
  output logic        lt24_rs,
  output logic        lt24_wr_n,
  output logic        lt24_rd_n,
  output logic [15:0] lt24_data
);

  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  localparam logic [15:0]   COL_LAST = 16'(H_RES - 1);
  localparam logic [15:0]   ROW_LAST = 16'(V_RES - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
  localparam logic [32:0]   SQ33     = 33'(SQ_SIZE);
`ifdef LT24_SEQ_INIT_EN
  localparam state_t RESET_STATE = ST_INIT_SLPOUT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t        r_state;
  logic [11:0]   r_pattern;
  logic [31:0]   r_vx;
  logic [31:0]   r_vy;
  logic [1:0]    r_idx;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [31:0]   r_counter;
  logic          r_finish;
`ifdef LT24_SEQ_INIT_EN
  logic [31:0]   r_wait;
  logic          w_wait_last;
  assign w_wait_last = (r_wait == 32'(INIT_WAIT - 1));
`endif

  logic          w_valid;
  logic          w_rs;
  logic [15:0]   w_data;
  logic          w_done;
  logic          w_cs_n;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_white;
  logic [15:0]   w_px_data;
  logic          w_last_px;
  logic          w_in_frame;

  assign w_last_px  = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_in_frame = r_state inside {ST_COL_CMD, ST_COL_DATA, ST_PAGE_CMD,
                                      ST_PAGE_DATA, ST_MEMWR_CMD, ST_PIXELS};

  // Coordinates of the pixel about to be issued (first pixel follows RAMWR).
  always_comb begin
    w_nx = '0;
    w_ny = '0;
    if (r_state == ST_PIXELS) begin
      if (r_x == X_LAST) begin
        w_nx = '0;
        w_ny = r_y + YW'(1);
      end else begin
        w_nx = r_x + XW'(1);
        w_ny = r_y;
      end
    end
  end

  // 33-bit compares so a sprite near 2^32 cannot wrap back onto the screen.
  assign w_white = ({1'b0, r_vx} <= 33'(w_nx)) && (33'(w_nx) < ({1'b0, r_vx} + SQ33)) &&
                   ({1'b0, r_vy} <= 33'(w_ny)) && (33'(w_ny) < ({1'b0, r_vy} + SQ33));
  assign w_px_data = w_white ? PIXEL_WHITE : rgb444_to_565(r_pattern);

  // NOTE: every combinational output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_valid = 1'b0;
    w_rs    = 1'b0;
    w_data  = 16'h0000;
    unique case (r_state)
`ifdef LT24_SEQ_INIT_EN
      ST_INIT_SLPOUT: if (w_cs_n) begin
        w_valid = 1'b1;
        w_data  = CMD_SLPOUT;
      end
      ST_INIT_WAIT: if (w_wait_last) begin
        w_valid = 1'b1;
        w_data  = CMD_DISPON;
      end
`endif
      ST_IDLE: if (start) begin
        w_valid = 1'b1;
        w_data  = CMD_CASET;
      end
      ST_COL_CMD: if (w_done) begin
        w_valid = 1'b1;
        w_rs    = 1'b1;
        w_data  = range_word(COL_LAST, 2'd0);
      end
      ST_COL_DATA: if (w_done) begin
        w_valid = 1'b1;
        w_rs    = (r_idx != 2'd3);
        w_data  = (r_idx == 2'd3) ? CMD_PASET : range_word(COL_LAST, r_idx + 2'd1);
      end
      ST_PAGE_CMD: if (w_done) begin
        w_valid = 1'b1;
        w_rs    = 1'b1;
        w_data  = range_word(ROW_LAST, 2'd0);
      end
      ST_PAGE_DATA: if (w_done) begin
        w_valid = 1'b1;
        w_rs    = (r_idx != 2'd3);
        w_data  = (r_idx == 2'd3) ? CMD_RAMWR : range_word(ROW_LAST, r_idx + 2'd1);
      end
      ST_MEMWR_CMD: if (w_done) begin
        w_valid = 1'b1;
        w_rs    = 1'b1;
        w_data  = w_px_data;
      end
      ST_PIXELS: if (w_done && !w_last_px) begin
        w_valid = 1'b1;
        w_rs    = 1'b1;
        w_data  = w_px_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      r_state   <= RESET_STATE;
      r_pattern <= '0;
      r_vx      <= '0;
      r_vy      <= '0;
      r_idx     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_counter <= '0;
      r_finish  <= 1'b0;
`ifdef LT24_SEQ_INIT_EN
      r_wait    <= '0;
`endif
    end else begin
      if (w_in_frame) r_counter <= r_counter + 32'd1;
      unique case (r_state)
`ifdef LT24_SEQ_INIT_EN
        ST_INIT_SLPOUT: if (w_done) begin
          r_state <= ST_INIT_WAIT;
          r_wait  <= '0;
        end
        ST_INIT_WAIT: begin
          if (w_wait_last) r_state <= ST_INIT_DISPON;
          else             r_wait  <= r_wait + 32'd1;
        end
        ST_INIT_DISPON: if (w_done) r_state <= ST_IDLE;
`endif
        ST_IDLE: if (start) begin
          r_pattern <= pattern;
          r_vx      <= vx;
          r_vy      <= vy;
          r_counter <= '0;
          r_finish  <= 1'b0;
          r_state   <= ST_COL_CMD;
        end
        ST_COL_CMD: if (w_done) begin
          r_idx   <= '0;
          r_state <= ST_COL_DATA;
        end
        ST_COL_DATA: if (w_done) begin
          if (r_idx == 2'd3) r_state <= ST_PAGE_CMD;
          else               r_idx   <= r_idx + 2'd1;
        end
        ST_PAGE_CMD: if (w_done) begin
          r_idx   <= '0;
          r_state <= ST_PAGE_DATA;
        end
        ST_PAGE_DATA: if (w_done) begin
          if (r_idx == 2'd3) r_state <= ST_MEMWR_CMD;
          else               r_idx   <= r_idx + 2'd1;
        end
        ST_MEMWR_CMD: if (w_done) begin
          r_x     <= '0;
          r_y     <= '0;
          r_state <= ST_PIXELS;
        end
        ST_PIXELS: if (w_done) begin
          if (w_last_px) begin
            r_state <= ST_DONE;
          end else begin
            r_x <= w_nx;
            r_y <= w_ny;
          end
        end
        ST_DONE: begin
          r_finish <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lt24_bus_writer u_bus_writer (
    .clk          (clock_clk),
    .rst_n        (reset_reset_n),
    .i_word_valid (w_valid),
    .i_word_rs    (w_rs),
    .i_word_data  (w_data),
    .o_word_done  (w_done),
    .o_cs_n       (w_cs_n),
    .o_rs         (lt24_rs),
    .o_wr_n       (lt24_wr_n),
    .o_data       (lt24_data)
  );

  assign lt24_cs_n   = w_cs_n;
  assign lt24_rd_n   = 1'b1;
  assign busy        = (r_state != ST_IDLE);
  assign finish_flag = r_finish;
  assign counter     = r_counter;

endmodule

// File: tb/tb_lt24_frame_sequencer.sv
// Self-checking bench for lt24_frame_sequencer on a 4x2 screen; exercises the
// LT24_SEQ_INIT_EN init sequence when that macro is defined.
module tb_lt24_frame_sequencer;

  localparam int H_RES     = 4;
  localparam int V_RES     = 2;
  localparam int SQ_SIZE   = 1;
  localparam int INIT_WAIT = 5;
  localparam int FRAME_CYC = 2 * (11 + H_RES * V_RES);
`ifdef LT24_SEQ_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  logic        clock_clk = 1'b0;
  logic        reset_reset_n;
  logic        start;
  logic [11:0] pattern;
  logic [31:0] vx;
  logic [31:0] vy;
  logic        busy;
  logic        finish_flag;
  logic [31:0] counter;
  logic        lt24_cs_n;
  logic        lt24_rs;
  logic        lt24_wr_n;
  logic        lt24_rd_n;
  logic [15:0] lt24_data;

  lt24_frame_sequencer #(
    .H_RES(H_RES), .V_RES(V_RES), .SQ_SIZE(SQ_SIZE), .INIT_WAIT(INIT_WAIT)
  ) dut (
    .clock_clk     (clock_clk),
    .reset_reset_n (reset_reset_n),
    .start         (start),
    .pattern       (pattern),
    .vx            (vx),
    .vy            (vy),
    .busy          (busy),
    .finish_flag   (finish_flag),
    .counter       (counter),
    .lt24_cs_n     (lt24_cs_n),
    .lt24_rs       (lt24_rs),
    .lt24_wr_n     (lt24_wr_n),
    .lt24_rd_n     (lt24_rd_n),
    .lt24_data     (lt24_data)
  );

  always #5 clock_clk = ~clock_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus monitor: one entry {rs,data} per word, stamped with its phase-0 cycle.
  logic [16:0] mon_q[$];
  int          mon_cyc[$];
  int          proto_err = 0;
  int          cyc = 0;
  logic        ph0_pending = 1'b0;
  logic [16:0] ph0_word;

  always begin
    @(posedge clock_clk);
    #1;
    cyc++;
    if (lt24_rd_n !== 1'b1) proto_err++;
    if (!reset_reset_n) begin
      ph0_pending = 1'b0;
    end else if (ph0_pending) begin
      if (lt24_cs_n !== 1'b0 || lt24_wr_n !== 1'b1 || {lt24_rs, lt24_data} !== ph0_word)
        proto_err++;
      ph0_pending = 1'b0;
    end else if (lt24_cs_n === 1'b0 && lt24_wr_n === 1'b0) begin
      ph0_word    = {lt24_rs, lt24_data};
      ph0_pending = 1'b1;
      mon_q.push_back(ph0_word);
      mon_cyc.push_back(cyc);
    end else if (lt24_cs_n === 1'b0 || lt24_wr_n === 1'b0) begin
      proto_err++;
    end
  end

  // Reference frame built straight from the display rules.
  logic [16:0] exp_q[$];

  function automatic void build_expected(input logic [11:0] p, input logic [31:0] x0,
                                         input logic [31:0] y0);
    longint lx = x0;
    longint ly = y0;
    int r = p[11:8];
    int g = p[7:4];
    int b = p[3:0];
    int bg = ((r * 2 + r / 8) << 11) | ((g * 4 + g / 4) << 5) | (b * 2 + b / 8);
    exp_q.delete();
    exp_q.push_back({1'b0, 16'h002A});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'((H_RES - 1) / 256)});
    exp_q.push_back({1'b1, 16'((H_RES - 1) % 256)});
    exp_q.push_back({1'b0, 16'h002B});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'((V_RES - 1) / 256)});
    exp_q.push_back({1'b1, 16'((V_RES - 1) % 256)});
    exp_q.push_back({1'b0, 16'h002C});
    for (int y = 0; y < V_RES; y++)
      for (int x = 0; x < H_RES; x++) begin
        if (x >= lx && x < lx + SQ_SIZE && y >= ly && y < ly + SQ_SIZE)
          exp_q.push_back({1'b1, 16'hFFFF});
        else
          exp_q.push_back({1'b1, 16'(bg)});
      end
  endfunction

  // All stimulus tasks start and end at posedge+2.
  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clock_clk);
      #2;
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulse_start(input logic [11:0] p, input logic [31:0] x0, input logic [31:0] y0);
    pattern = p;
    vx      = x0;
    vy      = y0;
    start   = 1'b1;
    @(posedge clock_clk);
    #2;
    start   = 1'b0;
  endtask

  task automatic compare_stream(input string tag);
    logic [16:0] act;
    check({tag, "_nwords"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < mon_q.size()) ? mon_q[i] : 17'bx;
      check($sformatf("%s_word%0d", tag, i), 32'(act), 32'(exp_q[i]));
    end
  endtask

  task automatic run_frame(input string tag, input logic [11:0] p, input logic [31:0] x0,
                           input logic [31:0] y0, input logic restart);
    build_expected(p, x0, y0);
    mon_q.delete();
    mon_cyc.delete();
    proto_err = 0;
    pulse_start(p, x0, y0);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    check({tag, "_finish_clr"}, 32'(finish_flag), 32'd0);
    if (restart) begin
      repeat (10) @(posedge clock_clk);
      #2;
      pulse_start(12'h0F0, 32'd0, 32'd0);
    end
    wait_idle({tag, "_idle"}, 200);
    compare_stream(tag);
    check({tag, "_counter"}, counter, 32'(FRAME_CYC));
    check({tag, "_finish"}, 32'(finish_flag), 32'd1);
    check({tag, "_proto"}, 32'(proto_err), 32'd0);
    repeat (4) @(posedge clock_clk);
    #2;
    check({tag, "_stays_idle"}, 32'(busy), 32'd0);
    check({tag, "_finish_hold"}, 32'(finish_flag), 32'd1);
    check({tag, "_counter_frozen"}, counter, 32'(FRAME_CYC));
  endtask

  task automatic check_init(input string tag);
    logic [16:0] w0;
    logic [16:0] w1;
    wait_idle({tag, "_idle"}, 100);
    w0 = (mon_q.size() > 0) ? mon_q[0] : 17'bx;
    w1 = (mon_q.size() > 1) ? mon_q[1] : 17'bx;
    check({tag, "_nwords"}, 32'(mon_q.size()), 32'd2);
    check({tag, "_slpout"}, 32'(w0), {15'd0, 1'b0, 16'h0011});
    check({tag, "_dispon"}, 32'(w1), {15'd0, 1'b0, 16'h0029});
    if (mon_cyc.size() > 1)
      check({tag, "_gap"}, 32'(mon_cyc[1] - mon_cyc[0]), 32'(2 + INIT_WAIT));
    check({tag, "_finish"}, 32'(finish_flag), 32'd0);
    check({tag, "_proto"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    reset_reset_n = 1'b0;
    start   = 1'b0;
    pattern = '0;
    vx      = '0;
    vy      = '0;
    repeat (3) @(posedge clock_clk);
    #1;
    check("rst_busy",    32'(busy),        32'(INIT_EN));
    check("rst_finish",  32'(finish_flag), 32'd0);
    check("rst_counter", counter,          32'd0);
    check("rst_cs_n",    32'(lt24_cs_n),   32'd1);
    check("rst_wr_n",    32'(lt24_wr_n),   32'd1);
    check("rst_rd_n",    32'(lt24_rd_n),   32'd1);
    check("rst_rs",      32'(lt24_rs),     32'd0);
    check("rst_data",    32'(lt24_data),   32'd0);
    mon_q.delete();
    mon_cyc.delete();
    #1;
    reset_reset_n = 1'b1;
    if (INIT_EN) check_init("init");
    else         wait_idle("post_rst_idle", 4);

    run_frame("red",    12'hF00, 32'd100, 32'd100, 1'b0);
    run_frame("corner", 12'h000, 32'd3,   32'd1,   1'b0);
    run_frame("offx",   12'h000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_frame("offy",   12'h5A3, 32'd0,   32'hFFFF_FFFF, 1'b0);
    run_frame("restart", 12'h00F, 32'd1,  32'd0,   1'b1);

    for (int k = 0; k < 6; k++) begin
      rx = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
      ry = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      run_frame($sformatf("rnd%0d", k), 12'($urandom_range(0, 4095)), rx, ry, 1'b0);
    end

    // Abort mid-frame: reset while pixel 4 (word 15) is in phase 0.
    mon_q.delete();
    mon_cyc.delete();
    proto_err = 0;
    pulse_start(12'h7C2, 32'd100, 32'd100);
    for (int n = 0; n < 100 && mon_q.size() < 16; n++) begin
      @(posedge clock_clk);
      #2;
    end
    check("abort_reach_px4", 32'(mon_q.size()), 32'd16);
    check("abort_px4_wr_n",  32'(lt24_wr_n), 32'd0);
    reset_reset_n = 1'b0;
    @(posedge clock_clk);
    #1;
    check("abort_wr_n",    32'(lt24_wr_n),   32'd1);
    check("abort_cs_n",    32'(lt24_cs_n),   32'd1);
    check("abort_busy",    32'(busy),        32'(INIT_EN));
    check("abort_finish",  32'(finish_flag), 32'd0);
    check("abort_counter", counter,          32'd0);
    mon_q.delete();
    mon_cyc.delete();
    #1;
    reset_reset_n = 1'b1;
    repeat (3) @(posedge clock_clk);
    #2;
    check("abort_no_strobe", 32'(proto_err), 32'd0);
    if (INIT_EN) begin
      mon_q.delete();
      mon_cyc.delete();
      wait_idle("abort_reinit_idle", 100);
    end else begin
      check("abort_quiet_bus", 32'(mon_q.size()), 32'd0);
      check("abort_still_idle", 32'(busy), 32'd0);
    end
    run_frame("recover", 12'h3C9, 32'd2, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
